data_mem_responder: RTL and testbench

- Responder side of the MEM-stage data-memory request interface: pipeline MEM stage issues load/store requests, this block services them after a fixed access latency.
- Holds the word-addressed data memory array, applies byte-enable merges on stores, returns read data with a one-cycle response strobe.
- Drives a stall to the hazard unit so the pipeline freezes while a request is in flight.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 98 +++++++++
 tb/tb_data_mem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage data-memory request/response bundle
interface data_mem_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    ReqValid;
   logic                    ReqWrite;
   logic [31:0]             ReqAddr;
   logic [DATA_WIDTH-1:0]   ReqWData;
   logic [DATA_WIDTH/8-1:0] ReqByteEn;
   logic                    ReqReady;
   logic                    RespValid;
   logic [DATA_WIDTH-1:0]   RespRData;
   logic                    AddrError;
   logic                    Stall;

   modport master (
      output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn,
      input  ReqReady, RespValid, RespRData, AddrError, Stall
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn,
      output ReqReady, RespValid, RespRData, AddrError, Stall
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder for the MEM stage
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 3
) (
   input  logic                Clk,
   input  logic                Rst,
   data_mem_responder_if.slave bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH    = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic                    accept, access;
   logic                    lat_write, lat_oor;
   logic [ADDR_WIDTH-1:0]   lat_idx;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [BE_WIDTH-1:0]     lat_be;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    aerr_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    unused_addr_lsb;

   assign unused_addr_lsb = ^bus.ReqAddr[1:0];

   always_ff @(posedge Clk) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: if (bus.ReqValid) begin
            accept    = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (cnt == 4'd0) begin
            access    = 1'b1;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request is captured once at acceptance; the MEM stage may drop its inputs during BUSY.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_oor   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else if (accept) begin
         cnt       <= 4'(LATENCY - 1);
         lat_write <= bus.ReqWrite;
         lat_oor   <= (bus.ReqAddr[31:ADDR_WIDTH+2] != '0);
         lat_idx   <= bus.ReqAddr[ADDR_WIDTH+1:2];
         lat_wdata <= bus.ReqWData;
         lat_be    <= bus.ReqByteEn;
      end else if (state == BUSY && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Memory has no reset; a reset edge during BUSY suppresses the pending write.
   always_ff @(posedge Clk) begin
      if (Rst && access && lat_write && !lat_oor) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         rdata_q <= '0;
         aerr_q  <= 1'b0;
      end else if (access) begin
         rdata_q <= (lat_write || lat_oor) ? '0 : mem[lat_idx];
         aerr_q  <= lat_oor;
      end
   end

   assign bus.ReqReady  = (state == IDLE);
   assign bus.RespValid = (state == RESP);
   assign bus.RespRData = rdata_q;
   assign bus.AddrError = aerr_q;
   assign bus.Stall     = (state == BUSY) || (state == IDLE && bus.ReqValid);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder (LATENCY 3 and 1)
module tb_data_mem_responder;
   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 Clk = ~Clk;

   data_mem_responder_if #(.DATA_WIDTH(32)) ifa ();
   data_mem_responder_if #(.DATA_WIDTH(32)) ifb ();

   data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(3)) dut_a (
      .Clk(Clk), .Rst(Rst), .bus(ifa.slave));
   data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) dut_b (
      .Clk(Clk), .Rst(Rst), .bus(ifb.slave));

   logic [31:0] rd;
   logic        ae;
   int          lat;
   logic        stall_req, stall_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction on instance A; lat counts cycles after the acceptance edge until RespValid.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
      @(negedge Clk);
      ifa.ReqValid  = 1'b1;
      ifa.ReqWrite  = w;
      ifa.ReqAddr   = a;
      ifa.ReqWData  = d;
      ifa.ReqByteEn = be;
      #1 stall_req = ifa.Stall;
      @(posedge Clk);
      #1;
      ifa.ReqValid  = 1'b0;
      ifa.ReqWData  = 32'h0;
      lat = 0; rd = 'x; ae = 'x; stall_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         lat++;
         if (lat == 1) stall_busy = ifa.Stall;
         if (ifa.RespValid) begin
            rd = ifa.RespRData;
            ae = ifa.AddrError;
            break;
         end
      end
   endtask

   initial begin
      int r1a, r2a, r1b, r2b, resp_cnt;
      logic rdy_in_resp;
      ifa.ReqValid = 0; ifa.ReqWrite = 0; ifa.ReqAddr = 0; ifa.ReqWData = 0; ifa.ReqByteEn = 0;
      ifb.ReqValid = 0; ifb.ReqWrite = 0; ifb.ReqAddr = 0; ifb.ReqWData = 0; ifb.ReqByteEn = 0;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b1;
      @(negedge Clk);
      chk("rst_respvalid", 32'(ifa.RespValid), 32'd0);
      chk("rst_rdata",     ifa.RespRData,      32'd0);
      chk("rst_aerr",      32'(ifa.AddrError), 32'd0);
      chk("rst_ready",     32'(ifa.ReqReady),  32'd1);
      chk("rst_stall",     32'(ifa.Stall),     32'd0);

      xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      chk("ld10_stall_req",  32'(stall_req),  32'd1);
      chk("ld10_stall_busy", 32'(stall_busy), 32'd1);
      chk("ld10_latency",    32'(lat),        32'd4);
      chk("ld10_aerr",       32'(ae),         32'd0);
      chk("ld10_resp_stall", 32'(ifa.Stall),  32'd0);
      @(negedge Clk);
      chk("ld10_one_cycle",  32'(ifa.RespValid), 32'd0);

      xact(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
      chk("st20_latency", 32'(lat), 32'd4);
      chk("st20_rdata",   rd,       32'd0);
      chk("st20_aerr",    32'(ae),  32'd0);
      xact(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      chk("ld20_full", rd, 32'hDEAD_BEEF);
      @(negedge Clk);
      chk("ld20_hold", ifa.RespRData, 32'hDEAD_BEEF);
      xact(1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1);
      xact(1'b0, 32'h0000_0023, 32'h0, 4'h0);
      chk("ld20_merge", rd, 32'hDEAD_BEAA);

      xact(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0);
      chk("st_be0_latency", 32'(lat), 32'd4);
      xact(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      chk("st_be0_noop", rd, 32'hDEAD_BEAA);

      xact(1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'hF);
      xact(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      chk("oor_ld_latency", 32'(lat), 32'd4);
      chk("oor_ld_aerr",    32'(ae),  32'd1);
      chk("oor_ld_rdata",   rd,       32'd0);
      xact(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
      chk("oor_st_aerr",    32'(ae),  32'd1);
      xact(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      chk("oor_alias_word0", rd,      32'h55AA_55AA);
      chk("oor_alias_aerr",  32'(ae), 32'd0);

      xact(1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF);
      @(negedge Clk);
      ifa.ReqValid = 1'b1; ifa.ReqWrite = 1'b1; ifa.ReqAddr = 32'h40;
      ifa.ReqWData = 32'h1234_5678; ifa.ReqByteEn = 4'hF;
      @(posedge Clk);
      #1 ifa.ReqValid = 1'b0;
      @(posedge Clk);
      #1 Rst = 1'b0;
      @(posedge Clk);
      #1 Rst = 1'b1;
      resp_cnt = 0;
      @(negedge Clk);
      chk("rstbusy_ready", 32'(ifa.ReqReady), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (ifa.RespValid) resp_cnt++;
         @(negedge Clk);
      end
      chk("rstbusy_no_resp", 32'(resp_cnt), 32'd0);
      xact(1'b0, 32'h0000_0040, 32'h0, 4'h0);
      chk("rstbusy_no_write", rd, 32'h1111_1111);

      // Both instances see ReqValid held high from the same cycle.
      @(negedge Clk);
      ifa.ReqValid = 1'b1; ifa.ReqWrite = 1'b0; ifa.ReqAddr = 32'h20;
      ifb.ReqValid = 1'b1; ifb.ReqWrite = 1'b0; ifb.ReqAddr = 32'h20;
      r1a = -1; r2a = -1; r1b = -1; r2b = -1; rdy_in_resp = 1'bx;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge Clk);
         else #1;
         if (ifa.RespValid) begin
            if (r1a < 0) begin r1a = c; rdy_in_resp = ifa.ReqReady; end
            else if (r2a < 0) r2a = c;
         end
         if (ifb.RespValid) begin
            if (r1b < 0) r1b = c;
            else if (r2b < 0) r2b = c;
         end
      end
      ifa.ReqValid = 1'b0;
      ifb.ReqValid = 1'b0;
      chk("b2b_first_a",   32'(r1a),         32'd4);
      chk("b2b_ready_resp", 32'(rdy_in_resp), 32'd0);
      chk("b2b_spacing_a", 32'(r2a - r1a),   32'd5);
      chk("b2b_first_b",   32'(r1b),         32'd2);
      chk("b2b_spacing_b", 32'(r2b - r1b),   32'd3);
      repeat (10) @(posedge Clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
